max_search_sched: RTL and testbench

MAX_SEARCH_SCHED -- requirements
Module: max_search_sched

---
 rtl/max_search_pkg.sv | 30 +++
 rtl/max_search_sched_rr_arbiter.sv | 34 +++
 rtl/max_search_sched.sv | 129 ++++++++++++
 tb/tb_max_search_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max_search_pkg.sv
// Shared types for the max-search job scheduler: FSM state encoding and the
// captured response record.
package max_search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Record fields are sized for the widest supported configuration
  // (DATA_WIDTH up to 32, up to 2^16 rows/cols/requesters); users slice.
  localparam int RSP_MAX_W = 34;
  localparam int RSP_IDX_W = 16;

  typedef struct packed {
    logic [RSP_MAX_W-1:0] max;
    logic [RSP_IDX_W-1:0] row;
    logic [RSP_IDX_W-1:0] col;
    logic                 err;
    logic [RSP_IDX_W-1:0] id;
  } rsp_t;

  // Single-step modulo wrap for values in [0, 2n).
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction

endpackage

// File: rtl/max_search_sched_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter
  import max_search_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 any_req
);

  localparam int W = $clog2(N);

  int   idx;
  logic found;

  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = wrap_idx(int'(ptr) + i, N);
      if (!found && req[idx[W-1:0]]) begin
        grant_id = W'(idx);
        found    = 1'b1;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/max_search_sched.sv
// Schedules one search job at a time onto a shared max-search engine,
// guarding each job with a watchdog and holding the result until consumed.
module max_search_sched
  import max_search_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int TIMEOUT    = 80
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       eng_start,
  output logic [$clog2(NUM_REQ)-1:0] eng_sel,
  input  logic                       eng_done,
  input  logic [DATA_WIDTH+1:0]      eng_max,
  input  logic [$clog2(ROWS)-1:0]    eng_row,
  input  logic [$clog2(COLS)-1:0]    eng_col,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [DATA_WIDTH+1:0]      rsp_max,
  output logic [$clog2(ROWS)-1:0]    rsp_row,
  output logic [$clog2(COLS)-1:0]    rsp_col,
  output logic                       rsp_err
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int MAX_W = DATA_WIDTH + 2;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  rsp_t              rsp_q, rsp_d;
  logic [SEL_W-1:0]  grant_id;
  logic              any_req;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      wd_q    <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      wd_q    <= wd_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    wd_d      = wd_q;
    rsp_d     = rsp_q;
    eng_start = 1'b0;
    rsp_valid = 1'b0;
    req_ready = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d   = grant_id;
          state_d = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        wd_d      = '0;
        state_d   = BUSY;
      end
      BUSY: begin
        wd_d = wd_q + 1'b1;
        // A result arriving on the last watchdog cycle still counts as success.
        if (eng_done) begin
          rsp_d.max = RSP_MAX_W'(eng_max);
          rsp_d.row = RSP_IDX_W'(eng_row);
          rsp_d.col = RSP_IDX_W'(eng_col);
          rsp_d.err = 1'b0;
          rsp_d.id  = RSP_IDX_W'(sel_q);
          state_d   = RESP;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          rsp_d     = '0;
          rsp_d.err = 1'b1;
          rsp_d.id  = RSP_IDX_W'(sel_q);
          state_d   = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          req_ready[sel_q] = 1'b1;
          ptr_d            = SEL_W'(wrap_idx(int'(sel_q) + 1, NUM_REQ));
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign eng_sel = sel_q;
  assign rsp_id  = rsp_q.id[SEL_W-1:0];
  assign rsp_max = rsp_q.max[MAX_W-1:0];
  assign rsp_row = rsp_q.row[ROW_W-1:0];
  assign rsp_col = rsp_q.col[COL_W-1:0];
  assign rsp_err = rsp_q.err;

  // Upper record bits beyond this configuration's widths are never read.
  logic unused_rsp_bits;
  assign unused_rsp_bits = ^rsp_q;

endmodule

// File: tb/tb_max_search_sched.sv
// Directed bench for max_search_sched with default parameters.
module tb_max_search_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid;
  logic [3:0] req_ready;
  logic       eng_start;
  logic [1:0] eng_sel;
  logic       eng_done;
  logic [9:0] eng_max;
  logic [2:0] eng_row;
  logic [2:0] eng_col;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_id;
  logic [9:0] rsp_max;
  logic [2:0] rsp_row;
  logic [2:0] rsp_col;
  logic       rsp_err;

  int n_chk   = 0;
  int n_fail  = 0;
  int n_starts = 0;

  max_search_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .eng_start (eng_start),
    .eng_sel   (eng_sel),
    .eng_done  (eng_done),
    .eng_max   (eng_max),
    .eng_row   (eng_row),
    .eng_col   (eng_col),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_max   (rsp_max),
    .rsp_row   (rsp_row),
    .rsp_col   (rsp_col),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (eng_start === 1'b1) n_starts++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (eng_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic chk_outputs_zero(input string pfx);
    chk({pfx, "_eng_start"}, eng_start, 0);
    chk({pfx, "_req_ready"}, req_ready, 0);
    chk({pfx, "_rsp_valid"}, rsp_valid, 0);
    chk({pfx, "_rsp_err"},   rsp_err,   0);
    chk({pfx, "_rsp_max"},   rsp_max,   0);
    chk({pfx, "_rsp_row"},   rsp_row,   0);
    chk({pfx, "_rsp_col"},   rsp_col,   0);
    chk({pfx, "_rsp_id"},    rsp_id,    0);
    chk({pfx, "_eng_sel"},   eng_sel,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic       ok;
    logic [3:0] onehot;
    int         base;
    int         exp_id;

    rst = 1'b1; req_valid = '0; eng_done = 1'b0;
    eng_max = '0; eng_row = '0; eng_col = '0; rsp_ready = 1'b0;
    tick(); tick();
    chk_outputs_zero("rst");
    rst = 1'b0;

    // single request from id 2, engine done on the 66th BUSY cycle
    req_valid = 4'b0100;
    wait_start(10, ok);
    chk("s1_start_seen", ok, 1);
    chk("s1_eng_sel", eng_sel, 2);
    tick();
    repeat (65) tick();
    chk("s1_busy_no_rsp", rsp_valid, 0);
    eng_done = 1'b1; eng_max = 10'h1F3; eng_row = 3'd5; eng_col = 3'd2;
    tick();
    eng_done = 1'b0; eng_max = '0; eng_row = '0; eng_col = '0;
    chk("s1_rsp_valid", rsp_valid, 1);
    chk("s1_rsp_id",    rsp_id,    2);
    chk("s1_rsp_max",   rsp_max,   10'h1F3);
    chk("s1_rsp_row",   rsp_row,   5);
    chk("s1_rsp_col",   rsp_col,   2);
    chk("s1_rsp_err",   rsp_err,   0);
    chk("s1_no_ready_yet", req_ready, 0);
    rsp_ready = 1'b1;
    #1;
    chk("s1_req_ready", req_ready, 4'b0100);
    tick();
    rsp_ready = 1'b0; req_valid = '0;
    #1;
    chk("s1_ready_one_cycle", req_ready, 0);
    chk("s1_idle_no_rsp", rsp_valid, 0);

    // all four requesting: order 0,1,2,3,0, one start per job
    rst = 1'b1; tick(); rst = 1'b0;
    base = n_starts;
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      exp_id = j % 4;
      onehot = 4'b0001 << exp_id;
      wait_start(10, ok);
      chk("rr_start_seen", ok, 1);
      chk("rr_eng_sel", eng_sel, exp_id);
      tick();
      eng_done = 1'b1; eng_max = 10'(j + 1); eng_row = 3'(j); eng_col = 3'(7 - j);
      tick();
      eng_done = 1'b0;
      chk("rr_rsp_id",  rsp_id,  exp_id);
      chk("rr_rsp_max", rsp_max, j + 1);
      rsp_ready = 1'b1;
      if (j == 4) req_valid = '0;
      #1;
      chk("rr_req_ready", req_ready, onehot);
      tick();
      rsp_ready = 1'b0;
    end
    chk("rr_start_count", n_starts - base, 5);

    // watchdog: ptr is 1, only id 0 requests (wrap), then drops request
    req_valid = 4'b0001;
    wait_start(10, ok);
    chk("wd_start_seen", ok, 1);
    chk("wd_eng_sel", eng_sel, 0);
    req_valid = '0;
    tick();
    repeat (79) tick();
    chk("wd_last_busy_no_rsp", rsp_valid, 0);
    tick();
    chk("wd_rsp_valid", rsp_valid, 1);
    chk("wd_rsp_err",   rsp_err,   1);
    chk("wd_rsp_max",   rsp_max,   0);
    chk("wd_rsp_row",   rsp_row,   0);
    chk("wd_rsp_col",   rsp_col,   0);
    chk("wd_rsp_id",    rsp_id,    0);

    // back-pressure: hold rsp_ready low for 10 cycles with others waiting
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_err",   rsp_err,   1);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_eng_start", eng_start, 0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", req_ready, 4'b0001);
    tick();
    rsp_ready = 1'b0;
    wait_start(10, ok);
    chk("bp_next_start_seen", ok, 1);
    chk("bp_ptr_advanced_sel", eng_sel, 1);

    // reset in BUSY discards the job
    req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk_outputs_zero("mid_rst");
    rst = 1'b0;
    req_valid = 4'b1000;
    wait_start(10, ok);
    chk("mr_start_seen", ok, 1);
    chk("mr_eng_sel", eng_sel, 3);

    // eng_done on the final watchdog cycle wins over timeout
    req_valid = '0;
    tick();
    repeat (79) tick();
    chk("edge_still_busy", rsp_valid, 0);
    eng_done = 1'b1; eng_max = 10'h3FF; eng_row = 3'd7; eng_col = 3'd7;
    tick();
    eng_done = 1'b0; eng_max = '0; eng_row = '0; eng_col = '0;
    chk("edge_rsp_valid", rsp_valid, 1);
    chk("edge_rsp_err",   rsp_err,   0);
    chk("edge_rsp_max",   rsp_max,   10'h3FF);
    chk("edge_rsp_row",   rsp_row,   7);
    chk("edge_rsp_col",   rsp_col,   7);
    chk("edge_rsp_id",    rsp_id,    3);
    rsp_ready = 1'b1;
    #1;
    chk("edge_req_ready", req_ready, 4'b1000);
    tick();
    rsp_ready = 1'b0;

    // eng_done while IDLE is ignored
    eng_done = 1'b1; eng_max = 10'h055; eng_row = 3'd1; eng_col = 3'd1;
    tick();
    eng_done = 1'b0; eng_max = '0; eng_row = '0; eng_col = '0;
    chk("idle_done_no_rsp",   rsp_valid, 0);
    chk("idle_done_no_start", eng_start, 0);
    chk("idle_done_max_kept", rsp_max,   10'h3FF);
    chk("idle_done_row_kept", rsp_row,   7);
    tick();
    chk("idle_done_still_idle", eng_start, 0);
    req_valid = 4'b0011;
    wait_start(10, ok);
    chk("wrap_start_seen", ok, 1);
    chk("wrap_eng_sel", eng_sel, 0);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
